// File: rtl/mem_data_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access is IDLE -> ACCESS -> DONE and ends in a one-cycle ack, flagged as an error if it timed out.
module mem_data_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_rdy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic [7:0] wait_cnt;

    logic       win;
    logic       win_we;
    logic [7:0] cnt_inc;
    logic       timeout_hit;
    logic       finish;
    logic       ack0_next;

    // Contention goes to the port that was not served last.
    assign win    = (p0_req && p1_req) ? ~last_grant : ~p0_req;
    assign win_we = win ? p1_we : p0_we;

    assign cnt_inc     = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign timeout_hit = !mem_rdy && (cnt_inc == 8'(TIMEOUT));
    assign finish      = (state == S_ACCESS) && (mem_rdy || timeout_hit);
    assign ack0_next   = finish && !grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            wait_cnt     <= 8'd0;
            p0_ack       <= 1'b0;
            p0_err       <= 1'b0;
            p1_ack       <= 1'b0;
            p1_err       <= 1'b0;
            rdata        <= '0;
            stall        <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_memRead  <= 1'b0;
            mem_memWrite <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;
            // Port 0 is not stalled in the cycle it is acked nor the one after, while it lowers req.
            stall  <= p0_req && !ack0_next && !((state == S_DONE) && !grant);
            case (state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        grant        <= win;
                        mem_addr     <= win ? p1_addr : p0_addr;
                        mem_data_in  <= win ? p1_wdata : p0_wdata;
                        mem_memRead  <= !win_we;
                        mem_memWrite <= win_we;
                        wait_cnt     <= 8'd0;
                        state        <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (finish) begin
                        if (mem_rdy && mem_memRead)
                            rdata <= mem_data_out;
                        mem_memRead  <= 1'b0;
                        mem_memWrite <= 1'b0;
                        p0_ack       <= !grant;
                        p1_ack       <= grant;
                        p0_err       <= !grant && timeout_hit;
                        p1_err       <= grant && timeout_hit;
                        state        <= S_DONE;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                S_DONE: begin
                    last_grant <= grant;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Random two-port traffic against a transaction-timing reference model:
// each grant predicts its strobe window, ack cycle, error flag and read data.
module tb_mem_data_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rq;
    logic [1:0]    wq;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic          p0_ack, p0_err, p1_ack, p1_err, stall;
    logic [DW-1:0] rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_addr;
    logic          mem_memRead, mem_memWrite, mem_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .p0_req(rq[0]), .p0_we(wq[0]), .p0_addr(ad[0]), .p0_wdata(wd[0]),
        .p1_req(rq[1]), .p1_we(wq[1]), .p1_addr(ad[1]), .p1_wdata(wd[1]),
        .p0_ack(p0_ack), .p0_err(p0_err), .p1_ack(p1_ack), .p1_err(p1_err),
        .rdata(rdata), .stall(stall),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_data_out(mem_data_out), .mem_rdy(mem_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rd"}, mem_memRead, 1'b0);
        chk({tag, "_wr"}, mem_memWrite, 1'b0);
        chk({tag, "_addr"}, mem_addr, '0);
        chk({tag, "_din"}, mem_data_in, '0);
        chk({tag, "_rdata"}, rdata, '0);
        chk({tag, "_acks"}, {p0_ack, p0_err, p1_ack, p1_err}, 4'b0);
        chk({tag, "_stall"}, stall, 1'b0);
    endtask

    // Model state: one access in flight at most, described by its grant sample and length.
    int            grant_t = -1, g_port, g_lat, g_len, ack_t, free_t, prev_ack0 = -10;
    logic          g_we, last, exp_err, in_rst, rst_done;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, exp_rdata, pend_rdata;
    logic          exp_strb, is_ack, ack0;

    initial begin
        reset = 1'b1; rq = '0; wq = '0; mem_rdy = 1'b0; mem_data_out = '0;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
        last = 1'b1; exp_rdata = '0; pend_rdata = '0; in_rst = 1'b0; rst_done = 1'b0;
        repeat (2) @(negedge clk);
        // Requests present during reset must not leak out.
        rq = 2'b11; wq = 2'b01;
        ad[0] = 11'h010; wd[0] = 32'h12345678; ad[1] = 11'h011; wd[1] = $urandom;
        @(negedge clk);
        chk_reset_state("reset");
        reset  = 1'b0;
        free_t = 1;
        for (int t = 1; t < NCYC; t++) begin
            @(negedge clk);
            if (in_rst) begin
                chk_reset_state("midrst");
                reset  = 1'b0;
                in_rst = 1'b0;
                free_t = t + 1;
                continue;
            end
            if (grant_t < 0 && t >= free_t && rq != 2'b00) begin
                g_port  = (rq == 2'b11) ? (last ? 0 : 1) : (rq[1] ? 1 : 0);
                grant_t = t;
                g_we    = wq[g_port];
                g_addr  = ad[g_port];
                g_wdata = wd[g_port];
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: g_lat = 0;
                    4, 5, 6, 7: g_lat = $urandom_range(1, 6);
                    default:    g_lat = $urandom_range(TO - 1, TO + 4);
                endcase
                g_len = (g_lat < TO) ? g_lat + 1 : TO;
                ack_t = t + g_len;
            end
            exp_strb = (grant_t >= 0) && (t < ack_t);
            is_ack   = (grant_t >= 0) && (t == ack_t);
            ack0     = is_ack && (g_port == 0);
            chk("strobe_rd", mem_memRead, exp_strb && !g_we);
            chk("strobe_wr", mem_memWrite, exp_strb && g_we);
            if (exp_strb) begin
                chk("mem_addr", mem_addr, g_addr);
                chk("mem_data_in", mem_data_in, g_wdata);
            end
            if (is_ack) begin
                exp_err = (g_lat >= TO);
                if (!exp_err && !g_we) exp_rdata = pend_rdata;
            end
            chk("p0_ack", p0_ack, ack0);
            chk("p1_ack", p1_ack, is_ack && (g_port == 1));
            chk("p0_err", p0_err, ack0 && exp_err);
            chk("p1_err", p1_err, is_ack && (g_port == 1) && exp_err);
            chk("rdata", rdata, exp_rdata);
            chk("stall", stall, rq[0] && !ack0 && (prev_ack0 != t - 1));
            if (is_ack) begin
                last       = (g_port == 1);
                free_t     = t + 2;
                if (g_port == 0) prev_ack0 = t;
                rq[g_port] = 1'b0;
                grant_t    = -1;
            end

            // Abort an access in flight once, then let the pending request be regranted.
            if (!rst_done && t >= NCYC / 2 && grant_t >= 0 && t > grant_t) begin
                rst_done = 1'b1;
                reset    = 1'b1;
                #1;
                chk_reset_state("async_rst");
                rq[g_port] = 1'b1;
                grant_t    = -1;
                last       = 1'b1;
                exp_rdata  = '0;
                prev_ack0  = -10;
                in_rst     = 1'b1;
                continue;
            end

            mem_data_out = $urandom;
            if (grant_t >= 0) mem_rdy = (g_lat < TO) && (t - grant_t == g_lat);
            else              mem_rdy = ($urandom_range(0, 3) == 0);
            if (grant_t >= 0 && mem_rdy) pend_rdata = mem_data_out;

            for (int p = 0; p < 2; p++) begin
                if (!rq[p] && !(grant_t >= 0 && g_port == p) && $urandom_range(0, 3) == 0) begin
                    rq[p] = 1'b1;
                    wq[p] = $urandom_range(0, 1) == 1;
                    ad[p] = AW'($urandom);
                    wd[p] = $urandom;
                end else if (rq[p] && grant_t >= 0 && g_port == p && t > grant_t
                             && $urandom_range(0, 15) == 0) begin
                    rq[p] = 1'b0;
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
